regfile_2r1w: RTL and testbench
===============================

Name: regfile_2r1w

Overview:
- Parametrised successor to the 4x8 lab register file.
- NREGS registers of WIDTH bits each, with two asynchronous read ports (A, B) and one synchronous write port.
- Adds:
  - optional edge-qualified writes, so one button press gives exactly one write;
  - read-during-write bypass;
  - per-register written flags;
  - a write counter and a write acknowledge pulse.
- Sits between the datapath/ALU and the board I/O wrapper; becomes the processor register file.

Parameters:
- WIDTH, 8: bits per register.
- NREGS, 4: number of registers; power of 2, at least 2.
- ADDR_W, $clog2(NREGS): select width; derived, not overridden.
- EDGE_WRITE, 1: 1 = write fires only on the rising edge of we; 0 = write fires every cycle we is high.
- BYPASS, 1: 1 = a read port returns data_w when its select matches a firing write; 0 = read returns the stored value.
- CNT_W, 8: width of write_count.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high; clears all state.
- we  in  1  write request, active-high.
- sel_w  in  ADDR_W  write register select.
- data_w  in  WIDTH  write data.
- sel_a  in  ADDR_W  read port A select.
- sel_b  in  ADDR_W  read port B select.
- data_a  out  WIDTH  port A read data (combinational).
- data_b  out  WIDTH  port B read data (combinational).
- written  out  NREGS  bit i = 1 when register i has been written since reset.
- write_count  out  CNT_W  number of fired writes, modulo 2^CNT_W.
- write_ack  out  1  one-cycle pulse, registered, in the cycle after a write fires.

Behaviour:
- Reset, asynchronous, takes effect immediately regardless of clk:
  - all registers = 0, written = 0, write_count = 0, write_ack = 0, we_q = 0.
  - Reset asserted mid-write: the write is lost and state stays cleared.
  - The first edge after reset deasserts is evaluated against we_q = 0.
- Write-fire condition, `fire`:
  - EDGE_WRITE=1: fire = we & ~we_q, where we_q is we registered every clk.
    - we held high for N cycles gives exactly one write, in its first cycle.
    - we must go low for at least 1 cycle before the next write.
  - EDGE_WRITE=0: fire = we. Holding we high gives a write every cycle; each write counts.
- On posedge clk with fire:
  - reg[sel_w] <= data_w;
  - written[sel_w] <= 1;
  - write_count <= write_count + 1, wrapping from 2^CNT_W-1 to 0;
  - write_ack <= 1.
- Without fire, write_ack <= 0 and all other state holds.
- Write latency: new data is visible on the read ports from the cycle after fire (BYPASS=0), or in the fire cycle itself (BYPASS=1).
- Reads:
  - data_a = reg[sel_a]; data_b = reg[sel_b]; purely combinational, no clock latency.
  - BYPASS=1 and fire and sel_x == sel_w: data_x = data_w.
  - Both ports may select the same register, including the one being written; both return the same value.
- Rewriting an already written register is a normal write: its written bit stays 1 and the counter increments.
- Everything is a flat register array, with no memory inference requirement. The select range is exactly 0..NREGS-1, so no out-of-range case exists.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined: register 0 is hardwired to zero (RISC-V x0 semantics).
  - A fire with sel_w = 0 is discarded: no storage change, no write_count increment, no write_ack.
    - With EDGE_WRITE=1, we_q still tracks we.
  - data_a/data_b return 0 for sel 0; bypass never applies to index 0.
  - written[0] reads constant 1.
- Undefined: register 0 behaves identically to all other registers.

Test Plan:
- Reset, then (WIDTH=8, NREGS=4, EDGE_WRITE=1, BYPASS=0):
  - sel_w=2, data_w=0x0A, we held high 5 cycles → R2=0x0A.
  - write_count=1, written=4'b0100, write_ack high exactly 1 cycle, data_a (sel_a=2)=0x0A from the next cycle.
- Same stimulus with EDGE_WRITE=0 → write_count=5 and write_ack high 5 consecutive cycles.
- BYPASS=1, R1=0x33, we rises with sel_w=1, data_w=0x5C, sel_a=sel_b=1 → data_a=data_b=0x5C in the fire cycle; R1=0x5C afterwards.
- CNT_W=8, 256 separate edge-qualified writes → write_count returns to 0x00; 257th write → 0x01.
- Write R3=0xFF, then assert reset asynchronously between clock edges → data_b (sel_b=3)=0x00, written=0, write_count=0 before the next clk edge.
- REGFILE_ZERO_REG_EN defined, write sel_w=0, data_w=0x77 → data_a (sel_a=0)=0x00, write_count unchanged, no write_ack, written[0]=1.
  - Undefined: the same stimulus gives 0x77, write_count+1, and a write_ack pulse.

Source files
------------

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: NREGS x WIDTH register file, two combinational read ports, one clocked write port; no backpressure.
// Writes land on the clk edge where they fire (visible same cycle with BYPASS); `REGFILE_ZERO_REG_EN hardwires register 0 to zero.
module regfile_2r1w #(
   parameter int WIDTH      = 8,
   parameter int NREGS      = 4,
   parameter int EDGE_WRITE = 1,
   parameter int BYPASS     = 1,
   parameter int CNT_W      = 8,
   localparam int ADDR_W    = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] sel_w,
   input  logic [WIDTH-1:0]  data_w,
   input  logic [ADDR_W-1:0] sel_a,
   input  logic [ADDR_W-1:0] sel_b,
   output logic [WIDTH-1:0]  data_a,
   output logic [WIDTH-1:0]  data_b,
   output logic [NREGS-1:0]  written,
   output logic [CNT_W-1:0]  write_count,
   output logic              write_ack
);

`ifdef REGFILE_ZERO_REG_EN
   localparam bit ZERO_REG = 1'b1;
`else
   localparam bit ZERO_REG = 1'b0;
`endif

   logic [WIDTH-1:0] regs_q [NREGS];
   logic [WIDTH-1:0] regs_d [NREGS];
   logic [NREGS-1:0] written_q, written_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ack_q, ack_d;
   logic             we_q;
   logic             fire_raw, fire;

   // we_q tracks we even when a write to the zero register is discarded
   assign fire_raw = (EDGE_WRITE != 0) ? (we & ~we_q) : we;
   assign fire     = fire_raw & ~(ZERO_REG && (sel_w == '0));

   always_comb begin
      regs_d    = regs_q;
      written_d = written_q;
      count_d   = count_q;
      ack_d     = 1'b0;
      if (fire) begin
         regs_d[sel_w]    = data_w;
         written_d[sel_w] = 1'b1;
         count_d          = count_q + CNT_W'(1);
         ack_d            = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
         written_q <= '0;
         count_q   <= '0;
         ack_q     <= 1'b0;
         we_q      <= 1'b0;
      end else begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
         written_q <= written_d;
         count_q   <= count_d;
         ack_q     <= ack_d;
         we_q      <= we;
      end
   end

   always_comb begin
      data_a = regs_q[sel_a];
      if ((BYPASS != 0) && fire && (sel_a == sel_w)) data_a = data_w;
      if (ZERO_REG && (sel_a == '0)) data_a = '0;
   end

   always_comb begin
      data_b = regs_q[sel_b];
      if ((BYPASS != 0) && fire && (sel_b == sel_w)) data_b = data_w;
      if (ZERO_REG && (sel_b == '0)) data_b = '0;
   end

   assign written     = written_q | NREGS'(ZERO_REG);
   assign write_count = count_q;
   assign write_ack   = ack_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: three instances (edge/no-bypass, level/no-bypass, edge/bypass) share one stimulus.
module tb_regfile_2r1w;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       we = 1'b0;
   logic [1:0] sel_w = '0, sel_a = '0, sel_b = '0;
   logic [7:0] data_w = '0;

   logic [7:0] da0, db0, cnt0, da1, db1, cnt1, da2, db2, cnt2;
   logic [3:0] wr0, wr1, wr2;
   logic       ack0, ack1, ack2;

   int checks = 0;
   int errors = 0;

`ifdef REGFILE_ZERO_REG_EN
   localparam logic [3:0] W0 = 4'b0001;
   localparam bit         ZR = 1'b1;
`else
   localparam logic [3:0] W0 = 4'b0000;
   localparam bit         ZR = 1'b0;
`endif

   always #5 clk = ~clk;

   regfile_2r1w #(.WIDTH(8), .NREGS(4), .EDGE_WRITE(1), .BYPASS(0), .CNT_W(8)) u0 (
      .clk(clk), .reset(reset), .we(we), .sel_w(sel_w), .data_w(data_w),
      .sel_a(sel_a), .sel_b(sel_b), .data_a(da0), .data_b(db0),
      .written(wr0), .write_count(cnt0), .write_ack(ack0));

   regfile_2r1w #(.WIDTH(8), .NREGS(4), .EDGE_WRITE(0), .BYPASS(0), .CNT_W(8)) u1 (
      .clk(clk), .reset(reset), .we(we), .sel_w(sel_w), .data_w(data_w),
      .sel_a(sel_a), .sel_b(sel_b), .data_a(da1), .data_b(db1),
      .written(wr1), .write_count(cnt1), .write_ack(ack1));

   regfile_2r1w #(.WIDTH(8), .NREGS(4), .EDGE_WRITE(1), .BYPASS(1), .CNT_W(8)) u2 (
      .clk(clk), .reset(reset), .we(we), .sel_w(sel_w), .data_w(data_w),
      .sel_a(sel_a), .sel_b(sel_b), .data_a(da2), .data_b(db2),
      .written(wr2), .write_count(cnt2), .write_ack(ack2));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      we = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // one-cycle we pulse; returns at the negedge after the write edge with we low
   task automatic wr(input logic [1:0] s, input logic [7:0] d);
      @(negedge clk);
      sel_w = s; data_w = d; we = 1'b1;
      @(negedge clk);
      we = 1'b0;
   endtask

   logic [5:0] ackv0, ackv1, ackv2;

   initial begin
      do_reset();
      #1;
      check("rst_cnt", cnt0, 0);
      check("rst_written", wr0, W0);
      check("rst_ack", ack0, 0);
      check("rst_data_a", da0, 0);

      // we held high for 5 cycles on R2
      @(negedge clk);
      sel_w = 2; data_w = 8'h0A; sel_a = 2; we = 1'b1;
      #1;
      check("nobyp_fire_cycle", da0, 8'h00);
      check("byp_fire_cycle", da2, 8'h0A);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         ackv0[i] = ack0; ackv1[i] = ack1; ackv2[i] = ack2;
         if (i == 0) check("data_a_after_fire", da0, 8'h0A);
         if (i == 4) begin
            @(negedge clk);
            we = 1'b0;
         end
      end
      check("edge_ack_pattern", ackv0, 6'b000001);
      check("level_ack_pattern", ackv1, 6'b011111);
      check("edge_byp_ack_pattern", ackv2, 6'b000001);
      check("edge_cnt", cnt0, 1);
      check("level_cnt", cnt1, 5);
      check("edge_written", wr0, 4'b0100 | W0);
      check("edge_R2", da0, 8'h0A);

      // bypass of a rewrite of R1
      wr(1, 8'h33);
      @(negedge clk);
      sel_w = 1; data_w = 8'h5C; sel_a = 1; sel_b = 1; we = 1'b1;
      #1;
      check("byp_a", da2, 8'h5C);
      check("byp_b", db2, 8'h5C);
      check("nobyp_old", da0, 8'h33);
      @(posedge clk); #1;
      check("byp_stored", da2, 8'h5C);
      check("nobyp_stored", da0, 8'h5C);
      check("rewrite_written", wr0, 4'b0110 | W0);
      @(negedge clk);
      we = 1'b0;

      // counter wrap
      do_reset();
      for (int i = 0; i < 256; i++) wr(2'(1 + (i % 3)), 8'(i));
      #1;
      check("wrap_cnt_edge", cnt0, 8'h00);
      check("wrap_cnt_level", cnt1, 8'h00);
      check("wrap_written", wr0, 4'b1110 | W0);
      wr(1, 8'h11);
      #1;
      check("wrap_257", cnt0, 8'h01);

      // asynchronous reset between clock edges
      wr(3, 8'hFF);
      sel_b = 3;
      #1;
      check("pre_areset_b", db0, 8'hFF);
      #2;
      reset = 1'b1;
      #1;
      check("areset_data_b", db0, 8'h00);
      check("areset_written", wr0, W0);
      check("areset_cnt", cnt0, 0);
      @(negedge clk);
      reset = 1'b0;

      // write to register 0
      @(negedge clk);
      sel_w = 0; data_w = 8'h77; sel_a = 0; we = 1'b1;
      @(posedge clk); #1;
      check("r0_ack", ack0, ZR ? 0 : 1);
      @(negedge clk);
      we = 1'b0;
      #1;
      check("r0_data_a", da0, ZR ? 8'h00 : 8'h77);
      check("r0_cnt", cnt0, ZR ? 0 : 1);
      check("r0_written0", wr0[0], 1);
      check("r0_byp_data_a", da2, ZR ? 8'h00 : 8'h77);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
